// File: rtl/alu_pkg.sv
// Shared ALU link types: packet/status encodings, response FSM states, flag record and CRC3 helper.
package alu_pkg;

  typedef enum logic {PKT_DATA = 1'b0, PKT_CTL = 1'b1} packet_t;
  typedef enum logic {STATUS_OK = 1'b0, STATUS_ERROR = 1'b1} status_t;

  localparam int FRAME_BITS    = 11;
  localparam int RSP_DATA_PKTS = 4;

  typedef struct packed {
    logic carry;
    logic overflow;
    logic zero;
    logic negative;
  } alu_flags_t;

  typedef enum logic [1:0] {IDLE = 2'd0, COLLECT = 2'd1, EMIT = 2'd2} rsp_state_t;
  typedef enum logic [1:0] {RX_IDLE = 2'd0, RX_SHIFT = 2'd1, RX_WAIT = 2'd2} rx_state_t;

  // Serial CRC, poly x^3+x+1, init 0, MSB first.
  function automatic bit [2:0] crc3(input bit [36:0] d);
    bit [2:0] c;
    bit       fb;
    c = 3'b000;
    for (int i = 36; i >= 0; i--) begin
      fb = c[2] ^ d[i];
      c  = {c[1], c[0] ^ fb, fb};
    end
    return c;
  endfunction

endpackage

// File: rtl/alu_rsp_deserializer_if.sv
// Bus between the ALU serial line and the response record consumer.
interface alu_rsp_deserializer_if
  import alu_pkg::*;
  ;
  logic       sout;
  logic       rsp_valid;
  status_t    rsp_status;
  logic [31:0] rsp_c;
  alu_flags_t rsp_flags;
  logic [5:0] rsp_err_flags;
  logic       rsp_chk_ok;
  logic       proto_err;

  modport master (
    output sout,
    input  rsp_valid, rsp_status, rsp_c, rsp_flags, rsp_err_flags, rsp_chk_ok, proto_err
  );

  modport slave (
    input  sout,
    output rsp_valid, rsp_status, rsp_c, rsp_flags, rsp_err_flags, rsp_chk_ok, proto_err
  );
endinterface

// File: rtl/alu_frame_rx.sv
// 11-bit frame receiver: start detect, type+payload shift, stop check.
// rx_idle is only present when ALU_RSP_TIMEOUT_EN is defined.
module alu_frame_rx
  import alu_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       sout,
`ifdef ALU_RSP_TIMEOUT_EN
  output logic       rx_idle,
`endif
  output logic       pkt_valid,
  output packet_t    pkt_type,
  output logic [7:0] pkt_data,
  output logic       frame_err
);

  localparam logic [3:0] LAST_BIT = 4'(FRAME_BITS - 2);

  rx_state_t  state_q, state_d;
  logic [3:0] bit_cnt_q, bit_cnt_d;
  logic [8:0] shift_q, shift_d;
  logic       pkt_valid_q, pkt_valid_d;
  packet_t    pkt_type_q, pkt_type_d;
  logic [7:0] pkt_data_q, pkt_data_d;
  logic       frame_err_q, frame_err_d;

  // Frame sequencing; after a bad stop bit the line must return high before hunting again.
  always_comb begin
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    shift_d     = shift_q;
    pkt_valid_d = 1'b0;
    pkt_type_d  = pkt_type_q;
    pkt_data_d  = pkt_data_q;
    frame_err_d = 1'b0;
    case (state_q)
      RX_IDLE: begin
        if (!sout) begin
          state_d   = RX_SHIFT;
          bit_cnt_d = 4'd0;
        end else begin
          state_d = RX_IDLE;
        end
      end
      RX_SHIFT: begin
        if (bit_cnt_q == LAST_BIT) begin
          state_d     = sout ? RX_IDLE : RX_WAIT;
          pkt_valid_d = sout;
          frame_err_d = !sout;
          pkt_type_d  = packet_t'(shift_q[8]);
          pkt_data_d  = shift_q[7:0];
          bit_cnt_d   = 4'd0;
        end else begin
          shift_d   = {shift_q[7:0], sout};
          bit_cnt_d = bit_cnt_q + 4'd1;
        end
      end
      RX_WAIT: begin
        if (sout) begin
          state_d = RX_IDLE;
        end else begin
          state_d = RX_WAIT;
        end
      end
      default: state_d = RX_IDLE;
    endcase
  end

  // Receiver state and registered packet outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= RX_IDLE;
      bit_cnt_q   <= 4'd0;
      shift_q     <= 9'd0;
      pkt_valid_q <= 1'b0;
      pkt_type_q  <= PKT_DATA;
      pkt_data_q  <= 8'd0;
      frame_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      shift_q     <= shift_d;
      pkt_valid_q <= pkt_valid_d;
      pkt_type_q  <= pkt_type_d;
      pkt_data_q  <= pkt_data_d;
      frame_err_q <= frame_err_d;
    end
  end

`ifdef ALU_RSP_TIMEOUT_EN
  assign rx_idle = (state_q == RX_IDLE);
`endif
  assign pkt_valid = pkt_valid_q;
  assign pkt_type  = pkt_type_q;
  assign pkt_data  = pkt_data_q;
  assign frame_err = frame_err_q;

endmodule

// File: rtl/alu_rsp_deserializer.sv
// ALU response receiver: reassembles DATA/CTL packets into one registered response record.
// Optional inter-packet timeout enabled by defining ALU_RSP_TIMEOUT_EN.
module alu_rsp_deserializer
  import alu_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 64
) (
  input logic                   clk,
  input logic                   rst_n,
  alu_rsp_deserializer_if.slave bus
);

  localparam logic [2:0] LAST_CNT = 3'(RSP_DATA_PKTS);

  logic       pkt_valid_s, frame_err_s, timeout_s;
  packet_t    pkt_type_s;
  logic [7:0] pkt_data_s;
  logic       emit_s;

  rsp_state_t  state_q, state_d;
  logic [2:0]  cnt_q, cnt_d;
  logic [31:0] c_acc_q, c_acc_d;
  logic [31:0] rsp_c_q, rsp_c_d;
  alu_flags_t  rsp_flags_q, rsp_flags_d;
  logic [5:0]  rsp_err_q, rsp_err_d;
  status_t     rsp_status_q, rsp_status_d;
  logic        chk_q, chk_d;
  logic        proto_q, proto_d;

`ifdef ALU_RSP_TIMEOUT_EN
  localparam int IW = $clog2(TIMEOUT_CYCLES + 1);
  logic          rx_idle_s;
  logic [IW-1:0] idle_q, idle_d;
`endif

  alu_frame_rx u_rx (
    .clk       (clk),
    .rst_n     (rst_n),
    .sout      (bus.sout),
`ifdef ALU_RSP_TIMEOUT_EN
    .rx_idle   (rx_idle_s),
`endif
    .pkt_valid (pkt_valid_s),
    .pkt_type  (pkt_type_s),
    .pkt_data  (pkt_data_s),
    .frame_err (frame_err_s)
  );

`ifdef ALU_RSP_TIMEOUT_EN
  // Idle counter runs only while a response is partially collected and no frame is arriving.
  always_comb begin
    if ((cnt_q != 3'd0) && rx_idle_s && !pkt_valid_s && !frame_err_s) begin
      if (idle_q == IW'(TIMEOUT_CYCLES - 1)) begin
        idle_d    = '0;
        timeout_s = 1'b1;
      end else begin
        idle_d    = idle_q + IW'(1);
        timeout_s = 1'b0;
      end
    end else begin
      idle_d    = '0;
      timeout_s = 1'b0;
    end
  end

  // Idle counter register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idle_q <= '0;
    end else begin
      idle_q <= idle_d;
    end
  end
`else
  assign timeout_s = 1'b0;
`endif

  // Packet decode: accumulate C bytes, build records, flag order/frame violations.
  always_comb begin
    cnt_d        = cnt_q;
    c_acc_d      = c_acc_q;
    rsp_c_d      = rsp_c_q;
    rsp_flags_d  = rsp_flags_q;
    rsp_err_d    = rsp_err_q;
    rsp_status_d = rsp_status_q;
    chk_d        = chk_q;
    proto_d      = 1'b0;
    emit_s       = 1'b0;
    if (frame_err_s) begin
      proto_d = 1'b1;
      cnt_d   = 3'd0;
    end else if (pkt_valid_s) begin
      if ((pkt_type_s == PKT_DATA) && (cnt_q < LAST_CNT)) begin
        case (cnt_q[1:0])
          2'd0:    c_acc_d[31:24] = pkt_data_s;
          2'd1:    c_acc_d[23:16] = pkt_data_s;
          2'd2:    c_acc_d[15:8]  = pkt_data_s;
          2'd3:    c_acc_d[7:0]   = pkt_data_s;
          default: c_acc_d        = c_acc_q;
        endcase
        cnt_d = cnt_q + 3'd1;
      end else if ((pkt_type_s == PKT_CTL) && (cnt_q == LAST_CNT) && !pkt_data_s[7]) begin
        rsp_c_d      = c_acc_q;
        rsp_flags_d  = alu_flags_t'(pkt_data_s[6:3]);
        rsp_status_d = STATUS_OK;
        chk_d        = (crc3({c_acc_q, 1'b0, pkt_data_s[6:3]}) == pkt_data_s[2:0]);
        emit_s       = 1'b1;
        cnt_d        = 3'd0;
      end else if ((pkt_type_s == PKT_CTL) && (cnt_q == 3'd0) && pkt_data_s[7]) begin
        rsp_err_d    = pkt_data_s[6:1];
        rsp_status_d = STATUS_ERROR;
        chk_d        = (pkt_data_s[0] == ^{1'b1, pkt_data_s[6:1]});
        emit_s       = 1'b1;
        cnt_d        = 3'd0;
      end else begin
        proto_d = 1'b1;
        cnt_d   = 3'd0;
      end
    end else if (timeout_s) begin
      proto_d = 1'b1;
      cnt_d   = 3'd0;
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Response FSM next state.
  always_comb begin
    if (emit_s) begin
      state_d = EMIT;
    end else if (cnt_d != 3'd0) begin
      state_d = COLLECT;
    end else begin
      state_d = IDLE;
    end
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Record and counter registers; record fields hold until the next emit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q        <= 3'd0;
      c_acc_q      <= 32'd0;
      rsp_c_q      <= 32'd0;
      rsp_flags_q  <= '0;
      rsp_err_q    <= 6'd0;
      rsp_status_q <= STATUS_OK;
      chk_q        <= 1'b0;
      proto_q      <= 1'b0;
    end else begin
      cnt_q        <= cnt_d;
      c_acc_q      <= c_acc_d;
      rsp_c_q      <= rsp_c_d;
      rsp_flags_q  <= rsp_flags_d;
      rsp_err_q    <= rsp_err_d;
      rsp_status_q <= rsp_status_d;
      chk_q        <= chk_d;
      proto_q      <= proto_d;
    end
  end

  // FSM outputs: the valid pulse is the single cycle spent in EMIT.
  always_comb begin
    bus.rsp_valid     = (state_q == EMIT);
    bus.rsp_status    = rsp_status_q;
    bus.rsp_c         = rsp_c_q;
    bus.rsp_flags     = rsp_flags_q;
    bus.rsp_err_flags = rsp_err_q;
    bus.rsp_chk_ok    = chk_q;
    bus.proto_err     = proto_q;
  end

endmodule
